i2c_master_ctrl: RTL and testbench
==================================

# i2c_master_ctrl

Single-byte I2C master controller: it drives SCL/SDA and issues one START, 7-bit address plus R/W, one data byte, then STOP per command. It is the initiator for the on-chip SRAM memory slave (device address 7'h1F), and lets a system-side host write or read one SRAM byte per transaction. It replaces bench-driven SCL/SDA stimulus in the I2C subsystem.

## Interface
- CLK_DIV, 4: `clk` cycles per SCL quarter-period; legal values ≥ 2. SCL period is 4*CLK_DIV.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  command request; sampled only in IDLE.
- rw  input  1  1 = read, 0 = write; latched with `start`.
- dev_addr  input  7  target address; latched with `start`.
- wr_data  input  8  write byte; latched with `start`.
- rd_data  output  8  byte received on a read; holds until the next read completes.
- busy  output  1  high from the cycle after `start` acceptance until `done`.
- done  output  1  one-cycle pulse when STOP completes.
- ack_err  output  1  valid with `done`: 1 if the address or write-data ACK was NACKed.
- SCL_I  input  1  sensed SCL line.
- SDA_I  input  1  sensed SDA line.
- SCL_O  output  1  SCL drive (1 = release/high).
- SDA_O  output  1  SDA drive (1 = release/high).

## Operation
- Reset values: SCL_O=1, SDA_O=1, busy=0, done=0, ack_err=0, rd_data=8'h00, state IDLE, counters 0.
- States: IDLE → START → ADDR → ADDR_ACK → (WDATA → WACK | RDATA → MACK) → STOP → IDLE.
- IDLE: `start`=1 latches rw/dev_addr/wr_data, clears ack_err, and moves to START.
- Each bit slot has 4 quarters (q0..q3) of CLK_DIV cycles. SCL_O is low in q0–q1 and high in q2–q3. SDA_O changes only at q0 entry. SDA_I is sampled on the last cycle of q2.
- START: SDA_O=1 and SCL_O=1 in q0–q1; SDA_O=0 with SCL_O=1 in q2–q3.
- ADDR: shift out {dev_addr, rw} MSB first, 8 slots; bit_cnt counts 7→0.
- ADDR_ACK: SDA_O=1. If sampled SDA_I=1, set ack_err and go to STOP.
- WDATA: shift wr_data MSB first. WACK: SDA_O=1; a sampled 1 sets ack_err. Then STOP.
- RDATA: SDA_O=1; shift the sampled bits into a shift register MSB first. MACK: master drives NACK (SDA_O=1), copies the shift register to rd_data, then STOP.
- STOP: q0 has SCL_O=0, SDA_O=0; q1 has SCL_O=1, SDA_O=0; q2–q3 have SDA_O=1, SCL_O=1. Then pulse `done`, drop busy, and return to IDLE.
- Clock stretching: in q2/q3, if SCL_O=1 and SCL_I=0, the quarter counter holds. There is no timeout.
- `start` while busy is ignored and not queued.
- A reset mid-transfer forces IDLE and releases SCL_O/SDA_O at that clock edge. No STOP is generated.

## Timing
- The `start` acceptance cycle is T0; busy=1 at T0+1.
- Full transaction is 20 slots: START, 8 ADDR, ACK, 8 DATA, ACK/MACK, STOP. `done` pulses at T0 + 80*CLK_DIV + 1 with no stretching.
- Address NACK is 11 slots; `done` pulses at T0 + 44*CLK_DIV + 1.
- Each stretched cycle adds exactly one cycle of latency.
- rd_data updates at the end of MACK and is stable before `done`.
- A new `start` is accepted in the cycle after `done`, at the earliest.

## Structure
- Shared package `i2c_pkg`:
  - state enum (4-bit encoding)
  - I2C_SRAM_ADDR = 7'h1F
  - RW_READ = 1'b1, RW_WRITE = 1'b0
  - quarter-phase constants Q0..Q3
- Sub-module `i2c_qtick_gen` holds the CLK_DIV counter, stretch hold and quarter index. Inputs are enable and stretch; outputs are q_idx[1:0], q_last and slot_end.
- The FSM, bit counter and shift registers live in the top module.

## Test plan
- Write 8'hA5 to 7'h1F with a responsive slave model: the bus shows address byte 8'h3E, then A5, ACKs, then STOP. Expect ack_err=0 and done at T0+321 (CLK_DIV=4).
- Read from 7'h1F with the slave returning 8'h3C: the bus shows address byte 8'h3F and the master sends NACK. Expect rd_data=8'h3C with done.
- Write to 7'h20 with no slave: expect a NACK on the address, ack_err=1, no data slots, STOP, and done at T0+177.
- Slave holds SCL_I low for 10 cycles during ADDR bit 3: expect the bits unchanged and done delayed by exactly 10 cycles.
- Assert rst=0 during RDATA bit 5: the next cycle shows SCL_O=SDA_O=1, busy=0 and rd_data unchanged. Then a new write completes normally.
- Pulse `start` while busy with different dev_addr/wr_data: expect the in-flight transfer unchanged and no second transaction.

Source files
------------

// File: rtl/i2c_master_ctrl_pkg.sv
// Shared types and constants for the single-byte I2C master and its users.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START    = 4'd1,
        ST_ADDR     = 4'd2,
        ST_ADDR_ACK = 4'd3,
        ST_WDATA    = 4'd4,
        ST_WACK     = 4'd5,
        ST_RDATA    = 4'd6,
        ST_MACK     = 4'd7,
        ST_STOP     = 4'd8
    } state_t;

    localparam logic [6:0] I2C_SRAM_ADDR = 7'h1F;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// Host command/status handshake plus the SCL/SDA drive and sense lines.
interface i2c_master_ctrl_if;

    logic       start;
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       SCL_I;
    logic       SDA_I;
    logic       SCL_O;
    logic       SDA_O;

    modport master (
        input  start, rw, dev_addr, wr_data, SCL_I, SDA_I,
        output rd_data, busy, done, ack_err, SCL_O, SDA_O
    );

    modport slave (
        output start, rw, dev_addr, wr_data, SCL_I, SDA_I,
        input  rd_data, busy, done, ack_err, SCL_O, SDA_O
    );

endinterface

// File: rtl/i2c_qtick_gen.sv
// Quarter-phase timebase: CLK_DIV cycles per quarter, four quarters per bit slot.
// While stretch is asserted the counter freezes, so every stretched cycle costs one cycle.
module i2c_qtick_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       stretch,
    output logic [1:0] q_idx,
    output logic       q_last,
    output logic       slot_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    q_q, q_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            q_q   <= Q0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    // Disabled means parked at the start of q0, ready for the next slot.
    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        if (!enable) begin
            cnt_d = '0;
            q_d   = Q0;
        end else if (!stretch) begin
            if (q_last) begin
                cnt_d = '0;
                q_d   = q_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign q_idx    = q_q;
    assign q_last   = (cnt_q == CW'(CLK_DIV - 1));
    assign slot_end = enable && (q_q == Q3) && q_last && !stretch;

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, one data byte, STOP per host command.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    i2c_master_ctrl_if.master  bus
);

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rw_q, rw_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       ack_err_q, ack_err_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [1:0] q_idx;
    logic       q_last;
    logic       slot_end;
    logic       stretch;
    logic       sample;
    logic       scl_o;
    logic       sda_o;

    i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk      (clk),
        .rst      (rst),
        .enable   (state_q != ST_IDLE),
        .stretch  (stretch),
        .q_idx    (q_idx),
        .q_last   (q_last),
        .slot_end (slot_end)
    );

    // A slave holding SCL low while we release it freezes the timebase.
    assign stretch = (q_idx >= Q2) && scl_o && !bus.SCL_I;
    assign sample  = (q_idx == Q2) && q_last && !stretch;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rd_data_q <= '0;
            rw_q      <= RW_WRITE;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rd_data_q <= rd_data_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Line drive: START and STOP move SDA mid-slot while SCL is high; data slots only at q0.
    always_comb begin
        scl_o = 1'b1;
        sda_o = 1'b1;
        case (state_q)
            ST_START: begin
                sda_o = (q_idx < Q2);
            end
            ST_ADDR, ST_WDATA: begin
                scl_o = (q_idx >= Q2);
                sda_o = tx_q[7];
            end
            ST_ADDR_ACK, ST_WACK, ST_RDATA, ST_MACK: begin
                scl_o = (q_idx >= Q2);
            end
            ST_STOP: begin
                scl_o = (q_idx != Q0);
                sda_o = (q_idx >= Q2);
            end
            default: ;
        endcase
    end

    // Sequencing; a done cycle blocks acceptance so a new command lands a cycle later.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rd_data_d = rd_data_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ack_err_d = ack_err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !done_q) begin
                    rw_d      = bus.rw;
                    addr_d    = bus.dev_addr;
                    wdata_d   = bus.wr_data;
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (slot_end) begin
                    tx_d      = {addr_q, rw_q};
                    bit_cnt_d = 3'd7;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR, ST_WDATA: begin
                if (slot_end) begin
                    tx_d = {tx_q[6:0], 1'b0};
                    if (bit_cnt_q == 3'd0) begin
                        state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
            end
            ST_ADDR_ACK: begin
                if (sample && bus.SDA_I) begin
                    ack_err_d = 1'b1;
                end
                if (slot_end) begin
                    bit_cnt_d = 3'd7;
                    if (ack_err_q) begin
                        state_d = ST_STOP;
                    end else if (rw_q == RW_READ) begin
                        state_d = ST_RDATA;
                    end else begin
                        tx_d    = wdata_q;
                        state_d = ST_WDATA;
                    end
                end
            end
            ST_WACK: begin
                if (sample && bus.SDA_I) begin
                    ack_err_d = 1'b1;
                end
                if (slot_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_RDATA: begin
                if (sample) begin
                    rx_d = {rx_q[6:0], bus.SDA_I};
                end
                if (slot_end) begin
                    if (bit_cnt_q == 3'd0) begin
                        state_d = ST_MACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
            end
            ST_MACK: begin
                if (slot_end) begin
                    rd_data_d = rx_q;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (slot_end) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.SCL_O   = scl_o;
    assign bus.SDA_O   = sda_o;
    assign bus.rd_data = rd_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a behavioural SRAM slave at 7'h1F on a wired-AND bus,
// a table of write/read/NACK commands, and hand sequences for stretch, reset and busy start.
module tb_i2c_master_ctrl;

    import i2c_pkg::*;

    localparam int CLK_DIV = 4;
    localparam logic [6:0] SLAVE_ADDR = I2C_SRAM_ADDR;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    i2c_master_ctrl_if bus();

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic       stretchLow = 1'b0;
    logic       slaveSda = 1'b1;
    logic [7:0] slaveReadByte = 8'h00;

    assign bus.SCL_I = bus.SCL_O & ~stretchLow;
    assign bus.SDA_I = bus.SDA_O & slaveSda;

    typedef enum int {S_IDLE, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_MACK} sphase_t;

    sphase_t    sPhase = S_IDLE;
    int         sBits = 0;
    logic [7:0] sShift = 8'h00;
    logic       sclPrev = 1'b1;
    logic       sdaPrev = 1'b1;
    logic [7:0] addrSeen = 8'h00;
    logic [7:0] dataSeen = 8'h00;
    logic       dataValid = 1'b0;
    logic       mackBit = 1'b0;
    logic       mackValid = 1'b0;
    int         startCount = 0;

    // Slave model: decodes START/STOP and SCL edges from the wired lines, ACKs its own
    // address and write data, and serves slaveReadByte MSB first on reads.
    always @(posedge clk) begin
        if (!rst) begin
            sPhase   <= S_IDLE;
            slaveSda <= 1'b1;
            sclPrev  <= 1'b1;
            sdaPrev  <= 1'b1;
            sBits    <= 0;
        end else begin
            sclPrev <= bus.SCL_I;
            sdaPrev <= bus.SDA_I;
            if (sclPrev && bus.SCL_I && sdaPrev && !bus.SDA_I) begin
                sPhase     <= S_ADDR;
                sBits      <= 0;
                slaveSda   <= 1'b1;
                dataValid  <= 1'b0;
                mackValid  <= 1'b0;
                startCount <= startCount + 1;
            end else if (sclPrev && bus.SCL_I && !sdaPrev && bus.SDA_I) begin
                sPhase   <= S_IDLE;
                slaveSda <= 1'b1;
            end else if (!sclPrev && bus.SCL_I) begin
                case (sPhase)
                    S_ADDR, S_WDATA: begin
                        sShift <= {sShift[6:0], bus.SDA_I};
                        sBits  <= sBits + 1;
                    end
                    S_RDATA: sBits <= sBits + 1;
                    S_MACK: begin
                        mackBit   <= bus.SDA_I;
                        mackValid <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (sclPrev && !bus.SCL_I) begin
                case (sPhase)
                    S_ADDR: begin
                        if (sBits == 8) begin
                            addrSeen <= sShift;
                            if (sShift[7:1] == SLAVE_ADDR) begin
                                slaveSda <= 1'b0;
                                sPhase   <= S_AACK;
                            end else begin
                                sPhase <= S_IDLE;
                            end
                        end
                    end
                    S_AACK: begin
                        sBits <= 0;
                        if (addrSeen[0]) begin
                            sPhase   <= S_RDATA;
                            slaveSda <= slaveReadByte[7];
                        end else begin
                            sPhase   <= S_WDATA;
                            slaveSda <= 1'b1;
                        end
                    end
                    S_WDATA: begin
                        if (sBits == 8) begin
                            dataSeen  <= sShift;
                            dataValid <= 1'b1;
                            slaveSda  <= 1'b0;
                            sPhase    <= S_WACK;
                        end
                    end
                    S_WACK: begin
                        slaveSda <= 1'b1;
                        sPhase   <= S_IDLE;
                    end
                    S_RDATA: begin
                        if (sBits == 8) begin
                            slaveSda <= 1'b1;
                            sPhase   <= S_MACK;
                        end else begin
                            slaveSda <= slaveReadByte[3'(7 - sBits)];
                        end
                    end
                    S_MACK: sPhase <= S_IDLE;
                    default: ;
                endcase
            end
        end
    end

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] slvByte;
        logic [7:0] expAddrByte;
        logic       expDataValid;
        logic [7:0] expData;
        logic       expAckErr;
        int         expDoneAt;
        logic [7:0] expRd;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One command: start pulse at T0, then wait (bounded) for done; optional extra
    // start pulse with unrelated operands while the transfer is in flight.
    task automatic applyStimulus(input logic rwIn, input logic [6:0] addrIn,
                                 input logic [7:0] dataIn, input int glitchAt,
                                 output int doneAt, output logic busyAt1,
                                 output logic ackErrAtDone, output logic [7:0] rdAtDone);
        int t0;
        @(negedge clk);
        bus.rw       = rwIn;
        bus.dev_addr = addrIn;
        bus.wr_data  = dataIn;
        bus.start    = 1'b1;
        t0           = cyc;
        @(negedge clk);
        bus.start    = 1'b0;
        busyAt1      = bus.busy;
        doneAt       = -1;
        ackErrAtDone = 1'b0;
        rdAtDone     = 8'h00;
        for (int i = 1; i < 2000; i++) begin
            if (bus.done) begin
                doneAt       = cyc - t0;
                ackErrAtDone = bus.ack_err;
                rdAtDone     = bus.rd_data;
                break;
            end
            if (i == glitchAt) begin
                bus.start    = 1'b1;
                bus.rw       = ~rwIn;
                bus.dev_addr = 7'h55;
                bus.wr_data  = 8'h0F;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic waitSclRise(input int n, output logic ok);
        int   seen;
        logic prev;
        seen = 0;
        ok   = 1'b0;
        prev = bus.SCL_O;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.SCL_O && !prev) seen++;
            prev = bus.SCL_O;
            if (seen == n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    int         doneAt;
    logic       busyAt1;
    logic       ackErr;
    logic [7:0] rdVal;
    logic       ok;
    logic       sOk;
    logic       sawBusy;
    int         startsBefore;

    initial begin
        bus.start    = 1'b0;
        bus.rw       = RW_WRITE;
        bus.dev_addr = 7'h00;
        bus.wr_data  = 8'h00;

        //                rw        addr   wdata  slv    addrB  dV    data   err   doneAt rd
        vecs[0] = '{RW_WRITE, 7'h1F, 8'hA5, 8'h00, 8'h3E, 1'b1, 8'hA5, 1'b0, 321, 8'h00};
        vecs[1] = '{RW_READ,  7'h1F, 8'h00, 8'h3C, 8'h3F, 1'b0, 8'h00, 1'b0, 321, 8'h3C};
        vecs[2] = '{RW_WRITE, 7'h20, 8'h77, 8'h00, 8'h40, 1'b0, 8'h00, 1'b1, 177, 8'h3C};
        vecs[3] = '{RW_READ,  7'h1F, 8'h00, 8'hC3, 8'h3F, 1'b0, 8'h00, 1'b0, 321, 8'hC3};
        vecs[4] = '{RW_READ,  7'h20, 8'h00, 8'h00, 8'h41, 1'b0, 8'h00, 1'b1, 177, 8'hC3};

        repeat (3) @(negedge clk);
        checkOutput("rst_scl",     32'(bus.SCL_O),   32'h1);
        checkOutput("rst_sda",     32'(bus.SDA_O),   32'h1);
        checkOutput("rst_busy",    32'(bus.busy),    32'h0);
        checkOutput("rst_done",    32'(bus.done),    32'h0);
        checkOutput("rst_ackerr",  32'(bus.ack_err), 32'h0);
        checkOutput("rst_rddata",  32'(bus.rd_data), 32'h00);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] reset during read data bit 5");
        slaveReadByte = 8'h96;
        bus.rw        = RW_READ;
        bus.dev_addr  = 7'h1F;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitSclRise(12, ok);
        checkOutput("mid_rst_reach", 32'(ok), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_scl",  32'(bus.SCL_O),   32'h1);
        checkOutput("mid_rst_sda",  32'(bus.SDA_O),   32'h1);
        checkOutput("mid_rst_busy", 32'(bus.busy),    32'h0);
        checkOutput("mid_rst_rd",   32'(bus.rd_data), 32'h00);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        applyStimulus(RW_WRITE, 7'h1F, 8'h5A, -1, doneAt, busyAt1, ackErr, rdVal);
        checkOutput("recov_done_at", 32'(doneAt),   32'd321);
        checkOutput("recov_ackerr",  32'(ackErr),   32'h0);
        checkOutput("recov_data",    32'(dataSeen), 32'h5A);
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            slaveReadByte = vecs[i].slvByte;
            applyStimulus(vecs[i].rw, vecs[i].addr, vecs[i].wdata, -1,
                          doneAt, busyAt1, ackErr, rdVal);
            checkOutput($sformatf("v%0d_busy_t1", i),  32'(busyAt1),   32'h1);
            checkOutput($sformatf("v%0d_done_at", i),  32'(doneAt),    32'(vecs[i].expDoneAt));
            checkOutput($sformatf("v%0d_ackerr", i),   32'(ackErr),    32'(vecs[i].expAckErr));
            checkOutput($sformatf("v%0d_rd_data", i),  32'(rdVal),     32'(vecs[i].expRd));
            checkOutput($sformatf("v%0d_addr_byte", i), 32'(addrSeen), 32'(vecs[i].expAddrByte));
            checkOutput($sformatf("v%0d_data_seen", i), 32'(dataValid), 32'(vecs[i].expDataValid));
            if (vecs[i].expDataValid)
                checkOutput($sformatf("v%0d_data", i), 32'(dataSeen), 32'(vecs[i].expData));
            if (vecs[i].rw == RW_READ && !vecs[i].expAckErr) begin
                checkOutput($sformatf("v%0d_mack_seen", i), 32'(mackValid), 32'h1);
                checkOutput($sformatf("v%0d_mack_nack", i), 32'(mackBit),   32'h1);
            end
            repeat (5) @(negedge clk);
        end

        $display("[TB] clock stretch during address bit 3");
        sOk = 1'b0;
        fork
            applyStimulus(RW_WRITE, 7'h1F, 8'hC6, -1, doneAt, busyAt1, ackErr, rdVal);
            begin
                waitSclRise(5, sOk);
                if (sOk) begin
                    stretchLow = 1'b1;
                    repeat (10) @(negedge clk);
                    stretchLow = 1'b0;
                end
            end
        join
        checkOutput("str_reach",   32'(sOk),      32'h1);
        checkOutput("str_done_at", 32'(doneAt),   32'd331);
        checkOutput("str_addr",    32'(addrSeen), 32'h3E);
        checkOutput("str_data",    32'(dataSeen), 32'hC6);
        checkOutput("str_ackerr",  32'(ackErr),   32'h0);
        repeat (5) @(negedge clk);

        $display("[TB] start pulse while busy");
        startsBefore = startCount;
        applyStimulus(RW_WRITE, 7'h1F, 8'h81, 100, doneAt, busyAt1, ackErr, rdVal);
        checkOutput("bsy_done_at", 32'(doneAt),   32'd321);
        checkOutput("bsy_addr",    32'(addrSeen), 32'h3E);
        checkOutput("bsy_data",    32'(dataSeen), 32'h81);
        checkOutput("bsy_ackerr",  32'(ackErr),   32'h0);
        sawBusy = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            sawBusy = sawBusy | bus.busy;
        end
        checkOutput("bsy_no_second", 32'(sawBusy),    32'h0);
        checkOutput("bsy_start_cnt", 32'(startCount), 32'(startsBefore + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
